// File: rtl/stack_ctrl.sv
// stack_ctrl: push/pop sequencer for a downward-growing stack in data memory.
// Owns the stack pointer (depth), runs one word transfer at a time over the
// shared data-memory port and stalls the ID stage while a request is in flight.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   push_req, pop_req   request strobes from the control unit (IDLE only)
//   push_data           word to push, sampled with push_req
//   mem_ack, mem_rdata  memory completion pulse and read data
//   mem_addr, mem_wdata latched transfer address / write data
//   mem_we, mem_re      write / read request, held until ack or abort
//   pop_data, pop_valid popped word and its one-cycle valid pulse
//   stall               hold PC and ID stage
//   depth               number of stacked words
//   overflow, underflow one-cycle rejection pulses
//   mem_err             one-cycle pulse: transfer aborted on timeout
module stack_ctrl #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] STACK_TOP = {ADDR_W{1'b1}},
  parameter int                DEPTH     = 16,
  parameter int                TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic [DATA_W-1:0] push_data,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              stall,
  output logic [ADDR_W:0]   depth,
  output logic              overflow,
  output logic              underflow,
  output logic              mem_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, PUSH, POP, BYPASS} state_t;

  state_t        state, state_n;
  logic [TW-1:0] tcnt;

  logic full, empty, swap, push_go, pop_go, timeout_hit;

  assign full        = (depth == FULL);
  assign empty       = (depth == '0);
  assign swap        = push_req & pop_req;
  assign push_go     = push_req & ~pop_req & ~full;
  assign pop_go      = pop_req & ~push_req & ~empty;
  // Last permitted ack-less cycle: abort instead of counting on.
  assign timeout_hit = (tcnt == TW'(TIMEOUT - 1)) & ~mem_ack;

  assign mem_we = (state == PUSH);
  assign mem_re = (state == POP);
  // Stall covers the request cycle too so the requester holds until done;
  // gated by reset so every output reads 0 while reset is asserted.
  assign stall  = rst & ((state != IDLE) | swap | push_go | pop_go);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (swap)         state_n = BYPASS;
        else if (push_go) state_n = PUSH;
        else if (pop_go)  state_n = POP;
      end
      PUSH, POP: if (mem_ack || timeout_hit) state_n = IDLE;
      BYPASS:    state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      depth     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      state     <= state_n;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (swap) begin
            pop_data  <= push_data;
            pop_valid <= 1'b1;
          end else if (push_req) begin
            if (full) overflow <= 1'b1;
            else begin
              mem_addr  <= STACK_TOP - depth[ADDR_W-1:0];
              mem_wdata <= push_data;
            end
          end else if (pop_req) begin
            if (empty) underflow <= 1'b1;
            else mem_addr <= STACK_TOP - depth[ADDR_W-1:0] + 1'b1;
          end
        end
        PUSH: begin
          if (mem_ack) begin
            depth <= depth + 1'b1;
            tcnt  <= '0;
          end else if (timeout_hit) begin
            mem_err <= 1'b1;
            tcnt    <= '0;
          end else tcnt <= tcnt + 1'b1;
        end
        POP: begin
          if (mem_ack) begin
            pop_data  <= mem_rdata;
            pop_valid <= 1'b1;
            depth     <= depth - 1'b1;
            tcnt      <= '0;
          end else if (timeout_hit) begin
            mem_err <= 1'b1;
            tcnt    <= '0;
          end else tcnt <= tcnt + 1'b1;
        end
        default: tcnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;
  localparam int DW = 32, AW = 8, DEPTH = 16, TIMEOUT = 15;
  localparam int TOP = 255;

  logic          clk = 0, rst = 0;
  logic          push_req = 0, pop_req = 0, mem_ack = 0;
  logic [DW-1:0] push_data = '0, mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, pop_data;
  logic          mem_we, mem_re, pop_valid, stall, overflow, underflow, mem_err;
  logic [AW:0]   depth;

  int checks = 0, errors = 0;

  // reference: stack contents as a queue (back = top), memory as an array
  logic [DW-1:0] stk[$];
  logic [DW-1:0] bmem[256];

  stack_ctrl #(.DATA_W(DW), .ADDR_W(AW), .STACK_TOP(8'hFF), .DEPTH(DEPTH),
               .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .push_req(push_req), .pop_req(pop_req),
    .push_data(push_data), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .pop_data(pop_data), .pop_valid(pop_valid),
    .stall(stall), .depth(depth), .overflow(overflow),
    .underflow(underflow), .mem_err(mem_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_re"}, mem_re, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_depth"}, depth, stk.size());
  endtask

  // ackdly: ack-less cycles before ack; <0 means never ack (timeout)
  task automatic do_push(input logic [DW-1:0] d, input int ackdly);
    int n, wc;
    logic [AW-1:0] a;
    a = AW'(TOP - stk.size());
    @(negedge clk);
    push_req = 1; push_data = d;
    #1;
    if (stk.size() == DEPTH) begin
      chk("ovf_stall", stall, 0);
      @(negedge clk);
      push_req = 0;
      chk("ovf_pulse", overflow, 1);
      chk_quiet("ovf");
      @(negedge clk);
      chk("ovf_clear", overflow, 0);
      return;
    end
    chk("push_req_stall", stall, 1);
    wc = 0;
    for (n = 0; n < TIMEOUT; n++) begin
      @(negedge clk);
      if (mem_we) wc++;
      chk("push_addr", mem_addr, a);
      chk("push_wdata", mem_wdata, d);
      chk("push_stall", stall, 1);
      if (n == ackdly) begin mem_ack = 1; push_req = 0; break; end
      if (n == TIMEOUT - 1) push_req = 0;
    end
    @(negedge clk);
    mem_ack = 0;
    if (ackdly < 0) begin
      chk("push_to_wecnt", wc, TIMEOUT);
      chk("push_to_err", mem_err, 1);
    end else begin
      chk("push_wecnt", wc, ackdly + 1);
      chk("push_err", mem_err, 0);
      bmem[a] = d;
      stk.push_back(d);
    end
    chk_quiet("push_done");
  endtask

  task automatic do_pop(input int ackdly, input bit rst_mid);
    int n, wc;
    logic [AW-1:0] a;
    a = AW'(TOP - stk.size() + 1);
    @(negedge clk);
    pop_req = 1;
    #1;
    if (stk.size() == 0) begin
      chk("udf_stall", stall, 0);
      @(negedge clk);
      pop_req = 0;
      chk("udf_pulse", underflow, 1);
      chk("udf_pv", pop_valid, 0);
      chk_quiet("udf");
      return;
    end
    chk("pop_req_stall", stall, 1);
    wc = 0;
    for (n = 0; n <= ackdly; n++) begin
      @(negedge clk);
      if (mem_re) wc++;
      chk("pop_addr", mem_addr, a);
      chk("pop_stall", stall, 1);
      if (rst_mid && n == 2) begin
        rst = 0; #1;
        chk("rst_re", mem_re, 0); chk("rst_stall", stall, 0);
        chk("rst_depth", depth, 0); chk("rst_addr", mem_addr, 0);
        chk("rst_pv", pop_valid, 0); chk("rst_err", mem_err, 0);
        pop_req = 0;
        stk.delete();
        @(negedge clk); rst = 1;
        @(negedge clk);
        chk_quiet("rst_idle");
        chk("rst_err2", mem_err, 0);
        return;
      end
      if (n == ackdly) begin mem_ack = 1; mem_rdata = bmem[a]; pop_req = 0; end
    end
    @(negedge clk);
    mem_ack = 0; mem_rdata = '0;
    chk("pop_recnt", wc, ackdly + 1);
    chk("pop_valid", pop_valid, 1);
    chk("pop_data", pop_data, stk.pop_back());
    chk_quiet("pop_done");
    @(negedge clk);
    chk("pop_valid_clr", pop_valid, 0);
  endtask

  task automatic do_swap(input logic [DW-1:0] d);
    @(negedge clk);
    push_req = 1; pop_req = 1; push_data = d;
    #1 chk("swap_req_stall", stall, 1);
    @(negedge clk);
    push_req = 0; pop_req = 0;
    chk("swap_pv", pop_valid, 1);
    chk("swap_data", pop_data, d);
    chk("swap_we", mem_we, 0);
    chk("swap_re", mem_re, 0);
    chk("swap_depth", depth, stk.size());
    @(negedge clk);
    chk("swap_pv_clr", pop_valid, 0);
    chk_quiet("swap_done");
  endtask

  initial begin
    #1;
    chk("rst_addr0", mem_addr, 0); chk("rst_depth0", depth, 0);
    chk("rst_pv0", pop_valid, 0);  chk("rst_stall0", stall, 0);
    chk("rst_we0", mem_we, 0);     chk("rst_err0", mem_err, 0);
    repeat (2) @(negedge clk);
    rst = 1;

    do_push(32'hA5A5_0001, 2);
    void'(stk.pop_back()); // rebuild a clean stack via pop below
    stk.push_back(32'hA5A5_0001);
    do_pop(0, 0);
    do_push(1, 0); do_push(2, 1); do_push(3, 4);
    do_pop(1, 0); do_pop(0, 0); do_pop(3, 0);
    do_pop(0, 0); // underflow
    for (int i = 0; i < DEPTH; i++) do_push(32'h100 + i, i % 3);
    do_push(32'hDEAD, 0); // overflow
    do_swap(32'h1234);
    do_push(32'hBEEF, -1); // timeout on full? no: full rejects; drain one first
    do_pop(0, 0);
    do_push(32'hBEEF, -1);
    @(negedge clk);
    chk("to_err_clr", mem_err, 0);
    // ack while idle must be ignored
    @(negedge clk); mem_ack = 1;
    @(negedge clk); mem_ack = 0;
    chk_quiet("idle_ack");
    while (stk.size() > 0) do_pop($urandom_range(0, 4), 0);
    // randomized mix against the queue model
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_push($urandom, $urandom_range(0, 6));
        4, 5, 6:    do_pop($urandom_range(0, 6), 0);
        7:          do_swap($urandom);
        8:          if (stk.size() < DEPTH) do_push($urandom, -1);
                    else do_pop(1, 0);
        default:    do_push($urandom, TIMEOUT - 1);
      endcase
    end
    if (stk.size() == 0) do_push(32'h77, 0);
    do_pop(8, 1); // reset during the POP wait
    do_push(32'h55, 0);
    do_pop(0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
